fusion_seq_ctrl: RTL

- Sequencer for one fusion unit (4-bit in/weight, 8-bit psum).
- Accepts a job of cfg_len operand pairs on a valid/ready stream and issues one pair per cycle to the unit.
- Tracks the unit's fixed pipeline latency and accumulates each returned psum into a wide accumulator.
- Presents the dot-product result on a valid/ready output; sits between the operand buffer/host and the fusion unit.

---
 rtl/fusion_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fusion_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fusion_seq_ctrl
//
// Sequencer for one fusion unit (4-bit input/weight, 8-bit partial sum).
// A job is started with cfg_start. It captures the job length and the
// precision/sign configuration. The controller then accepts cfg_len operand
// pairs on a valid/ready stream and issues one pair per cycle to the fusion
// unit. It tracks the unit's fixed pipeline latency with a shift register of
// valid bits and adds every returned psum into a wide accumulator. The
// dot-product result is offered on a valid/ready output.
//
// Optional build macro:
//   FUSION_SAT_EN - when defined, the accumulator saturates to the signed
//                   range (signed job) or the unsigned range (unsigned job),
//                   and res_ovf is a sticky clamp flag. When undefined, the
//                   accumulator wraps modulo 2^ACC_W and res_ovf stays 0.
//
// Parameters:
//   ACC_W  - accumulator / result width (>= 9)
//   LEN_W  - job length width; the longest job is 2^LEN_W-1 pairs
//   FU_LAT - cycles from issue on fu_* to a valid fu_psum (>= 1)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_start/cfg_len     start pulse and pair count (sampled in IDLE only)
//   cfg_in_width, cfg_weight_width, cfg_s_in, cfg_s_weight
//                         job configuration, captured with cfg_start
//   cfg_abort             abandon the current job, return to IDLE
//   busy                  high in every state except IDLE
//   op_valid/op_ready     operand pair stream (op_in, op_weight)
//   fu_in, fu_weight      registered operands to the fusion unit
//   fu_in_width, fu_weight_width, fu_s_in, fu_s_weight
//                         registered job configuration to the fusion unit
//   fu_psum               partial sum returned by the fusion unit
//   res_valid/res_ready   result handshake (res_data, res_ovf)
// ---------------------------------------------------------------------------
module fusion_seq_ctrl #(
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 8,
  parameter int FU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [2:0]       cfg_in_width,
  input  logic [2:0]       cfg_weight_width,
  input  logic             cfg_s_in,
  input  logic             cfg_s_weight,
  input  logic             cfg_abort,
  output logic             busy,
  input  logic             op_valid,
  input  logic [3:0]       op_in,
  input  logic [3:0]       op_weight,
  output logic             op_ready,
  output logic [3:0]       fu_in,
  output logic [3:0]       fu_weight,
  output logic [2:0]       fu_in_width,
  output logic [2:0]       fu_weight_width,
  output logic             fu_s_in,
  output logic             fu_s_weight,
  input  logic [7:0]       fu_psum,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  output logic             res_ovf,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state_reg;
  logic             busy_reg;
  logic             op_ready_reg;
  logic             res_valid_reg;

  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] issued_reg;
  logic [LEN_W-1:0] returned_reg;
  logic [LEN_W-1:0] issued_inc;
  logic [LEN_W-1:0] returned_inc;

  logic [3:0]       fu_in_reg;
  logic [3:0]       fu_weight_reg;
  logic [2:0]       fu_in_width_reg;
  logic [2:0]       fu_weight_width_reg;
  logic             fu_s_in_reg;
  logic             fu_s_weight_reg;

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_reg;
  logic             ovf_next;

  logic [FU_LAT-1:0] vpipe_reg;

  logic             xfer;
  logic             pop;
  logic             job_signed;
  logic [ACC_W-1:0] psum_ext;

  // op_ready_reg is only ever high in RUN, so it alone qualifies a transfer.
  assign xfer = op_valid & op_ready_reg;
  // The oldest valid bit marks the cycle in which fu_psum belongs to this job.
  assign pop  = vpipe_reg[FU_LAT-1];

  assign issued_inc   = issued_reg + LEN_ONE;
  assign returned_inc = returned_reg + LEN_ONE;

  // A job counts as signed when either operand is signed, so the psum
  // is sign-extended in that case.
  assign job_signed = fu_s_in_reg | fu_s_weight_reg;
  assign psum_ext   = job_signed ? {{(ACC_W-8){fu_psum[7]}}, fu_psum}
                                 : {{(ACC_W-8){1'b0}}, fu_psum};

  // -------------------------------------------------------------------------
  // Accumulator update
  // -------------------------------------------------------------------------
`ifdef FUSION_SAT_EN
  // One guard bit is enough to detect overflow of a single addition.
  logic [ACC_W:0] sum_w;

  always_comb begin
    sum_w    = '0;
    acc_next = '0;
    ovf_next = ovf_reg;
    if (job_signed) begin
      sum_w = {acc_reg[ACC_W-1], acc_reg} + {psum_ext[ACC_W-1], psum_ext};
      if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
        // The guard bit holds the true sign and picks the clamp direction.
        acc_next = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_w[ACC_W-1:0];
      end
    end else begin
      sum_w = {1'b0, acc_reg} + {1'b0, psum_ext};
      if (sum_w[ACC_W]) begin
        acc_next = {ACC_W{1'b1}};
        ovf_next = 1'b1;
      end else begin
        acc_next = sum_w[ACC_W-1:0];
      end
    end
  end
`else
  always_comb begin
    acc_next = acc_reg + psum_ext;
    ovf_next = 1'b0;
  end
`endif

  // -------------------------------------------------------------------------
  // Latency tracking: one valid bit per pipeline stage of the fusion unit.
  // An abort clears the pipe, so late psums from an abandoned job are never
  // added into a later job.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < FU_LAT; gi++) begin : g_vpipe
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vpipe_reg[gi] <= 1'b0;
          end else if (cfg_abort) begin
            vpipe_reg[gi] <= 1'b0;
          end else begin
            vpipe_reg[gi] <= xfer;
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            vpipe_reg[gi] <= 1'b0;
          end else if (cfg_abort) begin
            vpipe_reg[gi] <= 1'b0;
          end else begin
            vpipe_reg[gi] <= vpipe_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg           <= S_IDLE;
      busy_reg            <= 1'b0;
      op_ready_reg        <= 1'b0;
      res_valid_reg       <= 1'b0;
      len_reg             <= '0;
      issued_reg          <= '0;
      returned_reg        <= '0;
      fu_in_reg           <= '0;
      fu_weight_reg       <= '0;
      fu_in_width_reg     <= '0;
      fu_weight_width_reg <= '0;
      fu_s_in_reg         <= 1'b0;
      fu_s_weight_reg     <= 1'b0;
      acc_reg             <= '0;
      ovf_reg             <= 1'b0;
    end else if (cfg_abort) begin
      // Abort wins over a coincident transfer, accumulate or result handshake.
      state_reg     <= S_IDLE;
      busy_reg      <= 1'b0;
      op_ready_reg  <= 1'b0;
      res_valid_reg <= 1'b0;
    end else begin
      // Returned psums are added in whichever state they arrive. This can be
      // the same cycle as the last operand transfer.
      if (pop) begin
        acc_reg      <= acc_next;
        ovf_reg      <= ovf_next;
        returned_reg <= returned_inc;
      end

      case (state_reg)
        S_IDLE: begin
          if (cfg_start) begin
            len_reg             <= cfg_len;
            issued_reg          <= '0;
            returned_reg        <= '0;
            acc_reg             <= '0;
            ovf_reg             <= 1'b0;
            fu_in_width_reg     <= cfg_in_width;
            fu_weight_width_reg <= cfg_weight_width;
            fu_s_in_reg         <= cfg_s_in;
            fu_s_weight_reg     <= cfg_s_weight;
            busy_reg            <= 1'b1;
            if (cfg_len != '0) begin
              state_reg    <= S_RUN;
              op_ready_reg <= 1'b1;
            end else begin
              // An empty job presents a zero result on the next cycle.
              state_reg     <= S_DONE;
              res_valid_reg <= 1'b1;
            end
          end
        end

        S_RUN: begin
          // On cycles without a transfer, fu_in/fu_weight keep their last values.
          if (xfer) begin
            fu_in_reg     <= op_in;
            fu_weight_reg <= op_weight;
            issued_reg    <= issued_inc;
            if (issued_inc == len_reg) begin
              state_reg    <= S_DRAIN;
              op_ready_reg <= 1'b0;
            end
          end
        end

        S_DRAIN: begin
          // Leave DRAIN on the same edge that adds the final psum, so the
          // result is valid FU_LAT+1 cycles after the last transfer.
          if (pop && (returned_inc == len_reg)) begin
            state_reg     <= S_DONE;
            res_valid_reg <= 1'b1;
          end
        end

        S_DONE: begin
          if (res_ready) begin
            state_reg     <= S_IDLE;
            busy_reg      <= 1'b0;
            res_valid_reg <= 1'b0;
          end
        end

        default: begin
          state_reg     <= S_IDLE;
          busy_reg      <= 1'b0;
          op_ready_reg  <= 1'b0;
          res_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign busy            = busy_reg;
  assign op_ready        = op_ready_reg;
  assign fu_in           = fu_in_reg;
  assign fu_weight       = fu_weight_reg;
  assign fu_in_width     = fu_in_width_reg;
  assign fu_weight_width = fu_weight_width_reg;
  assign fu_s_in         = fu_s_in_reg;
  assign fu_s_weight     = fu_s_weight_reg;
  assign res_valid       = res_valid_reg;
  assign res_data        = acc_reg;
  // Without FUSION_SAT_EN, ovf_next is constant 0, so this output stays 0.
  assign res_ovf         = ovf_reg;

endmodule
